// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared control-bundle layout and ALUOp encodings
//
// Purpose: single source for the 10-bit decode control bundle layout
//   {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0], Branch}
//   (MSB first) and the ALUOp encodings used by decode and EX.
// Ports: none (package).
package id_ex_stage_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the control bundle.
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,  // loads, stores, addi
    ALUOP_SUB   = 3'b001,  // branch compare
    ALUOP_RTYPE = 3'b010,  // use funct field
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_LUI   = 3'b110,
    ALUOP_XOR   = 3'b111
  } aluop_e;

  function automatic logic [2:0] ctrl_aluop(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute pipeline bundle with master/slave modports
//
// Purpose: groups the ID-side fields, pipeline controls and EX-side outputs.
// master: decode/hazard control side (drives id_*, flush, hold; reads ex_*, stall).
// slave : the ID/EX stage (reads id_*, flush, hold; drives ex_*, ex_dst, stall).
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
);

  logic              id_valid;
  logic [RW-1:0]     id_rs;
  logic [RW-1:0]     id_rt;
  logic [RW-1:0]     id_rd;
  logic [DW-1:0]     id_rd1;
  logic [DW-1:0]     id_rd2;
  logic [DW-1:0]     id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  logic              flush;
  logic              hold;

  logic              ex_valid;
  logic [RW-1:0]     ex_rs;
  logic [RW-1:0]     ex_rt;
  logic [RW-1:0]     ex_rd;
  logic [DW-1:0]     ex_rd1;
  logic [DW-1:0]     ex_rd2;
  logic [DW-1:0]     ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RW-1:0]     ex_dst;
  logic              stall;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
    output flush, hold,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl,
    input  ex_dst, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
    input  flush, hold,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl,
    output ex_dst, stall
  );

endinterface

// File: rtl/id_ex_hazard.sv
// rtl/id_ex_hazard.sv - combinational load-use hazard detector
//
// Purpose: flags an ID instruction that reads the register a load in EX is
//   still fetching from memory. $0 is never a hazard.
// Ports: ex_valid, ex_mem_read, ex_rt (EX load), id_valid, id_rs, id_rt
//   (decode sources) in; load_use out.
module id_ex_hazard #(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          load_use
);

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush
//
// Purpose: registers decode fields into EX. Per edge exactly one action,
//   priority hold > flush (live or pending) > load-use bubble > normal load.
//   A flush that arrives during hold is remembered in flush_pend and applied
//   on the first unheld edge.
// Ports: clk, rst_n (async active-low); bus (id_ex_stage_if.slave) carrying
//   id_*, flush, hold in and ex_*, ex_dst, stall out.
// Config: ID_EX_BUBBLE_CNT_EN adds bubble_cnt[15:0], a saturating count of
//   loaded bubbles (load-use and flush), frozen while hold=1.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]  bubble_cnt
`endif
);

  logic              ex_valid_q,   ex_valid_d;
  logic [RW-1:0]     ex_rs_q,      ex_rs_d;
  logic [RW-1:0]     ex_rt_q,      ex_rt_d;
  logic [RW-1:0]     ex_rd_q,      ex_rd_d;
  logic [DW-1:0]     ex_rd1_q,     ex_rd1_d;
  logic [DW-1:0]     ex_rd2_q,     ex_rd2_d;
  logic [DW-1:0]     ex_imm_q,     ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic              flush_pend_q, flush_pend_d;

  logic load_use;
  logic eff_flush;
  logic load_bubble;

  id_ex_hazard #(.RW(RW)) u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt       (ex_rt_q),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .load_use    (load_use)
  );

  always_comb begin
    eff_flush    = bus.flush | flush_pend_q;
    load_bubble  = 1'b0;

    ex_valid_d   = ex_valid_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_rd1_d     = ex_rd1_q;
    ex_rd2_d     = ex_rd2_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    flush_pend_d = flush_pend_q;

    if (bus.hold) begin
      // Freeze everything; only remember a flush we could not act on yet.
      flush_pend_d = flush_pend_q | bus.flush;
    end else if (eff_flush || load_use) begin
      // Flush wins over load-use: the dependent instruction is being killed
      // anyway, so it must not be stalled and replayed.
      load_bubble  = 1'b1;
      ex_valid_d   = 1'b0;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_rd_d      = '0;
      ex_rd1_d     = '0;
      ex_rd2_d     = '0;
      ex_imm_d     = '0;
      ex_ctrl_d    = '0;
      flush_pend_d = 1'b0;
    end else begin
      ex_valid_d   = bus.id_valid;
      ex_rs_d      = bus.id_rs;
      ex_rt_d      = bus.id_rt;
      ex_rd_d      = bus.id_rd;
      ex_rd1_d     = bus.id_rd1;
      ex_rd2_d     = bus.id_rd2;
      ex_imm_d     = bus.id_imm;
      ex_ctrl_d    = bus.id_valid ? bus.id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rd1_q     <= '0;
      ex_rd2_q     <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd1_q     <= ex_rd1_d;
      ex_rd2_q     <= ex_rd2_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  // stall freezes PC and IF/ID: on hold, or on a load-use that a flush does
  // not pre-empt. Gated by rst_n so it reads 0 throughout reset.
  assign bus.stall = rst_n & (bus.hold | (load_use & ~eff_flush));

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_rs    = ex_rs_q;
  assign bus.ex_rt    = ex_rt_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_rd1   = ex_rd1_q;
  assign bus.ex_rd2   = ex_rd2_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.ex_ctrl  = ex_ctrl_q;

  // Destination seen by forwarding; 0 means "writes nothing".
  assign bus.ex_dst = (ex_valid_q & ex_ctrl_q[CTRL_REGWRITE]) ?
                      (ex_ctrl_q[CTRL_REGDST] ? ex_rd_q : ex_rt_q) : '0;

endmodule
